rop_ba_regfile_p: RTL

- Parametrised, sub-word-addressable general-purpose register file for the rop datapath, generalising the original byte-addressable regfile.
- Provides two read ports and one write port, each supporting byte, halfword, word and full-width accesses.
- Read ports support optional sign extension; the write port has a ready/valid handshake.
- Optional same-cycle write-to-read bypass.
- A sequential scrub engine zeroes every register after reset or on request; register storage itself is not reset.

---
 rtl/rop_regfile_pkg.sv | 63 ++++++
 rtl/rop_lane_extract.sv | 44 ++++
 rtl/rop_ba_regfile_p.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rop_regfile_pkg.sv
// Shared definitions for the rop byte-addressable register file.
//   - access size encodings (SZ_*)
//   - scrub engine state encoding
//   - lane helpers: byte count, aligned byte offset and byte-enable mask
//     for a (size, sub_addr) pair at a given register width.
package rop_regfile_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } scrub_state_t;

  // Number of bytes touched by an access; a word access on a 32-bit
  // register is the same as a full access.
  function automatic int lane_bytes(input logic [1:0] size, input int xlen);
    int n;
    case (size)
      SZ_BYTE: n = 1;
      SZ_HALF: n = 2;
      SZ_WORD: n = 4;
      default: n = xlen / 8;
    endcase
    if (n > xlen / 8) n = xlen / 8;
    return n;
  endfunction

  // Byte offset with the low bits dropped so the access is size aligned.
  function automatic int lane_offset(input logic [1:0] size, input logic [2:0] sub_addr,
                                     input int xlen);
    int n;
    n = lane_bytes(size, xlen);
    return int'(sub_addr) & (xlen / 8 - 1) & ~(n - 1);
  endfunction

  // Byte-enable vector; bit i set when byte i of the register is accessed.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] sub_addr,
                                           input int xlen);
    int n;
    int off;
    logic [7:0] m;
    n   = lane_bytes(size, xlen);
    off = lane_offset(size, sub_addr, xlen);
    m   = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Single bit of lane_mask, for per-byte generate loops.
  function automatic logic lane_en(input logic [1:0] size, input logic [2:0] sub_addr,
                                   input int xlen, input int lane);
    logic [7:0] m;
    m = lane_mask(size, sub_addr, xlen);
    return m[lane];
  endfunction

endpackage

// File: rtl/rop_lane_extract.sv
// Extracts the addressed lane of a register value and zero/sign extends it.
//   value    : full register value
//   size     : access size (SZ_*)
//   sub_addr : byte offset, aligned down to the access size
//   sgn      : 1 = sign extend sub-word results (ignored for full size)
//   result   : LSB-aligned extended lane
module rop_lane_extract
  import rop_regfile_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] value,
  input  logic [1:0]      size,
  input  logic [SW-1:0]   sub_addr,
  input  logic            sgn,
  output logic [XLEN-1:0] result
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ext_word;

  assign shamt   = 6'(lane_offset(size, 3'(sub_addr), XLEN) * 8);
  assign shifted = value >> shamt;

  // On a 32-bit register a word access is a full access, so no extension.
  if (XLEN > 32) begin : g_word_ext
    assign ext_word = {{(XLEN-32){sgn & shifted[31]}}, shifted[31:0]};
  end else begin : g_word_full
    assign ext_word = shifted;
  end

  always_comb begin
    result = shifted;
    case (size)
      SZ_BYTE: result = {{(XLEN-8){sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result = {{(XLEN-16){sgn & shifted[15]}}, shifted[15:0]};
      SZ_WORD: result = ext_word;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/rop_ba_regfile_p.sv
// Sub-word addressable register file: two combinational read ports (A, B),
// one ready/valid write port (C) and a scrub engine that zeroes every
// register after reset or on clr_req. Register 0 always reads zero.
//   clk, resetn                   : clock, async active-low reset
//   a_*/b_*                       : read address, size, byte offset, signed, data
//   c_valid/c_ready               : write handshake
//   c_reg_addr/c_size/c_sub_addr  : write target and lane
//   c_wdata                       : LSB-aligned write data
//   clr_req/clr_busy/clr_done     : scrub request, in-progress flag, completion pulse
module rop_ba_regfile_p
  import rop_regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int RW = $clog2(NREGS),
  localparam int SW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [RW-1:0]   a_reg_addr,
  input  logic [1:0]      a_size,
  input  logic [SW-1:0]   a_sub_addr,
  input  logic            a_signed,
  output logic [XLEN-1:0] a_rdata,
  input  logic [RW-1:0]   b_reg_addr,
  input  logic [1:0]      b_size,
  input  logic [SW-1:0]   b_sub_addr,
  input  logic            b_signed,
  output logic [XLEN-1:0] b_rdata,
  input  logic            c_valid,
  output logic            c_ready,
  input  logic [RW-1:0]   c_reg_addr,
  input  logic [1:0]      c_size,
  input  logic [SW-1:0]   c_sub_addr,
  input  logic [XLEN-1:0] c_wdata,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] regs_reg [NREGS];
  scrub_state_t    state_reg, state_next;
  logic [RW-1:0]   ptr_reg, ptr_next;

  logic            wr_accept;
  logic [5:0]      wr_shamt;
  logic [XLEN-1:0] wr_shifted, wr_old, wr_merged;
  logic            a_hit, b_hit;
  logic [XLEN-1:0] a_word, b_word;

  // Write merge: addressed bytes come from c_wdata shifted into the lane.
  assign wr_accept  = c_valid && c_ready;
  assign wr_shamt   = 6'(lane_offset(c_size, 3'(c_sub_addr), XLEN) * 8);
  assign wr_shifted = c_wdata << wr_shamt;
  assign wr_old     = regs_reg[c_reg_addr];

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_merge
    assign wr_merged[gi*8 +: 8] = lane_en(c_size, 3'(c_sub_addr), XLEN, gi)
                                ? wr_shifted[gi*8 +: 8] : wr_old[gi*8 +: 8];
  end

  // Storage is deliberately unreset; the scrub engine defines its contents.
  // Writes are only accepted in IDLE, so they never collide with a scrub.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CLEAR) begin
      regs_reg[ptr_reg] <= '0;
    end else if (wr_accept && (c_reg_addr != '0)) begin
      regs_reg[c_reg_addr] <= wr_merged;
    end
  end

  // Read word selection, with optional same-cycle forwarding of the write.
  assign a_hit  = (BYPASS != 0) && wr_accept && (c_reg_addr == a_reg_addr);
  assign b_hit  = (BYPASS != 0) && wr_accept && (c_reg_addr == b_reg_addr);
  assign a_word = (a_reg_addr == '0) ? '0 : (a_hit ? wr_merged : regs_reg[a_reg_addr]);
  assign b_word = (b_reg_addr == '0) ? '0 : (b_hit ? wr_merged : regs_reg[b_reg_addr]);

  rop_lane_extract #(.XLEN(XLEN)) u_extract_a (
    .value    (a_word),
    .size     (a_size),
    .sub_addr (a_sub_addr),
    .sgn      (a_signed),
    .result   (a_rdata)
  );

  rop_lane_extract #(.XLEN(XLEN)) u_extract_b (
    .value    (b_word),
    .size     (b_size),
    .sub_addr (b_sub_addr),
    .sgn      (b_signed),
    .result   (b_rdata)
  );

  // Scrub engine: register 0 needs no clearing, so the sweep runs 1..NREGS-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= RW'(1);
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    clr_done   = 1'b0;
    clr_busy   = 1'b0;
    c_ready    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        c_ready = 1'b1;
        if (clr_req) begin
          state_next = ST_CLEAR;
          ptr_next   = RW'(1);
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        if (ptr_reg == RW'(NREGS - 1)) begin
          clr_done   = 1'b1;
          state_next = ST_IDLE;
          ptr_next   = RW'(1);
        end else begin
          ptr_next = ptr_reg + RW'(1);
        end
      end
    endcase
  end

endmodule
